// File: rtl/serv_dbus_ram.sv
// serv_dbus_ram: wishbone dbus RAM responder with wait states and byte lanes; SERV_DBUS_RAM_ERR_EN adds o_wb_err for out-of-range requests
module serv_dbus_ram #(
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_busy
`ifdef SERV_DBUS_RAM_ERR_EN
  , output logic      o_wb_err
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [AW-3:0] adr_q, a_adr;
  logic [31:0] dat_q, a_dat;
  logic [3:0] sel_q, a_sel;
  logic we_q, a_we, oor_q, oor_in, a_oor, use_in, accept, access, wr;
  logic [31:0] mem [DEPTH/4];
  logic unused;
  assign unused = &{1'b0, i_wb_adr[31:AW], i_wb_adr[1:0]};
`ifdef SERV_DBUS_RAM_ERR_EN
  assign oor_in = |i_wb_adr[31:AW];
  assign o_wb_err = (state == S_ACK) && oor_q;
`else
  assign oor_in = 1'b0;
`endif
  assign accept = (state == S_IDLE) && i_wb_cyc;
  assign use_in = state == S_IDLE;
  assign a_adr = use_in ? i_wb_adr[AW-1:2] : adr_q;
  assign a_dat = use_in ? i_wb_dat : dat_q;
  assign a_sel = use_in ? i_wb_sel : sel_q;
  assign a_we = use_in ? i_wb_we : we_q;
  assign a_oor = use_in ? oor_in : oor_q;
  assign access = (accept && WAIT_STATES == 0) || (state == S_WAIT && cnt == 4'd0);
  assign wr = access && a_we && !a_oor && !i_rst;
  assign o_wb_ack = state == S_ACK;
  assign o_busy = state != S_IDLE;
  // next state and wait counter
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      S_IDLE: if (i_wb_cyc) begin
        state_n = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        cnt_n = 4'(WAIT_STATES - 1);
      end
      S_WAIT: begin
        state_n = (cnt == 4'd0) ? S_ACK : S_WAIT;
        cnt_n = (cnt == 4'd0) ? cnt : cnt - 4'd1;
      end
      S_ACK: state_n = S_HOLD;
      default: state_n = S_IDLE;
    endcase
  end
  // state register and request latch
  always_ff @(posedge i_clk) begin
    state <= i_rst ? S_IDLE : state_n;
    cnt <= i_rst ? 4'd0 : cnt_n;
    if (accept) begin
      adr_q <= i_wb_adr[AW-1:2];
      dat_q <= i_wb_dat;
      sel_q <= i_wb_sel;
      we_q <= i_wb_we;
      oor_q <= oor_in;
    end
  end
  // load data, held between loads
  always_ff @(posedge i_clk) begin
    if (i_rst) o_wb_rdt <= 32'd0;
    else if (access && !a_we) o_wb_rdt <= a_oor ? 32'd0 : mem[a_adr];
  end
  // byte-lane store, not reset
  always_ff @(posedge i_clk) begin
    if (wr)
      for (int n = 0; n < 4; n++)
        if (a_sel[n]) mem[a_adr][8*n +: 8] <= a_dat[8*n +: 8];
  end
endmodule

// File: tb/tb_serv_dbus_ram.sv
// tb_serv_dbus_ram: random and directed wishbone traffic against a word-array model, at 0 and 3 wait states
module tb_serv_dbus_ram;
  logic clk = 1'b0;
  logic [1:0] rst, cyc, we, ack, busy;
  logic [1:0][31:0] adr, dat, rdt;
  logic [1:0][3:0] sel;
`ifdef SERV_DBUS_RAM_ERR_EN
  logic [1:0] err;
`endif
  logic [31:0] ref_mem [2][256];
  logic [31:0] last_rdt [2];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    serv_dbus_ram #(.DEPTH(1024), .WAIT_STATES(g * 3)) u_dut (
      .i_clk(clk), .i_rst(rst[g]), .i_wb_adr(adr[g]), .i_wb_dat(dat[g]),
      .i_wb_sel(sel[g]), .i_wb_we(we[g]), .i_wb_cyc(cyc[g]),
      .o_wb_rdt(rdt[g]), .o_wb_ack(ack[g]), .o_busy(busy[g])
`ifdef SERV_DBUS_RAM_ERR_EN
      , .o_wb_err(err[g])
`endif
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic txn(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
    int n;
    int ws;
    logic oor;
    logic [31:0] exp;
    ws = u * 3;
    oor = 1'b0;
`ifdef SERV_DBUS_RAM_ERR_EN
    oor = |a[31:10];
`endif
    exp = oor ? 32'd0 : ref_mem[u][a[9:2]];
    chk("idle_busy", {31'd0, busy[u]}, 32'd0);
    adr[u] = a; dat[u] = d; sel[u] = s; we[u] = w; cyc[u] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack[u] && n < 20);
    chk("ack_latency", n, ws + 1);
`ifdef SERV_DBUS_RAM_ERR_EN
    chk("err", {31'd0, err[u]}, {31'd0, oor});
`endif
    if (!w) begin
      chk("load_rdt", rdt[u], exp);
      last_rdt[u] = exp;
    end else if (!oor)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[u][a[9:2]][8*b +: 8] = d[8*b +: 8];
    cyc[u] = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("ack_pulse", {31'd0, ack[u]}, 32'd0);
    chk("hold_busy", {31'd0, busy[u]}, 32'd1);
    cyc[u] = 1'b0;
    @(posedge clk); #1;
    chk("no_second_ack", {31'd0, ack[u]}, 32'd0);
    chk("rdt_hold", rdt[u], last_rdt[u]);
  endtask
  task automatic rst_mid(input int u, input logic [31:0] a, input logic [31:0] d);
    adr[u] = a; dat[u] = d; sel[u] = 4'hF; we[u] = 1'b1; cyc[u] = 1'b1;
    repeat (u * 3) begin
      @(posedge clk); #1;
    end
    rst[u] = 1'b1;
    @(posedge clk); #1;
    rst[u] = 1'b0; cyc[u] = 1'b0;
    last_rdt[u] = 32'd0;
    chk("rst_no_ack", {31'd0, ack[u]}, 32'd0);
    chk("rst_busy", {31'd0, busy[u]}, 32'd0);
    @(posedge clk); #1;
    chk("rst_stay_idle", {31'd0, ack[u]}, 32'd0);
  endtask
  initial begin
    logic [31:0] a;
    rst = 2'b11; cyc = 2'b00; we = 2'b00; adr = '0; dat = '0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 2'b00;
    for (int u = 0; u < 2; u++) begin
      chk("reset_ack", {31'd0, ack[u]}, 32'd0);
      chk("reset_busy", {31'd0, busy[u]}, 32'd0);
      chk("reset_rdt", rdt[u], 32'd0);
`ifdef SERV_DBUS_RAM_ERR_EN
      chk("reset_err", {31'd0, err[u]}, 32'd0);
`endif
      last_rdt[u] = 32'd0;
    end
    for (int u = 0; u < 2; u++) begin
      for (int w = 0; w < 256; w++) txn(u, 32'(w * 4), $urandom, 4'hF, 1'b1);
      txn(u, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
      txn(u, 32'h10, 32'd0, 4'hF, 1'b0);
      chk("deadbeef", rdt[u], 32'hDEADBEEF);
      txn(u, 32'h20, 32'h11223344, 4'hF, 1'b1);
      txn(u, 32'h20, 32'h000000AA, 4'b0001, 1'b1);
      txn(u, 32'h20, 32'h0000BB00, 4'b0010, 1'b1);
      txn(u, 32'h20, 32'd0, 4'hF, 1'b0);
      chk("byte_lanes", rdt[u], 32'h1122BBAA);
      txn(u, 32'h4, 32'h12345678, 4'hF, 1'b1);
      txn(u, 32'h404, 32'h55, 4'b0001, 1'b1);
      txn(u, 32'h004, 32'd0, 4'hF, 1'b0);
`ifdef SERV_DBUS_RAM_ERR_EN
      chk("alias_blocked", rdt[u], 32'h12345678);
`else
      chk("alias", rdt[u], 32'h12345655);
`endif
      txn(u, 32'h30, 32'h600DF00D, 4'hF, 1'b1);
      rst_mid(u, 32'h30, 32'hCAFEF00D);
      txn(u, 32'h30, 32'd0, 4'hF, 1'b0);
      chk("rst_write_dropped", rdt[u], 32'h600DF00D);
      for (int i = 0; i < 150; i++) begin
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a[31:10] = '0;
        txn(u, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
